// File: rtl/stage_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_fifo_if
// Brief    : Producer/consumer handshake bundle for the stage_fifo buffer.
// Revision : 1.0
// ============================================================================
interface stage_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      data_IN;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      data_OUT;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;

  modport slave (
    input  flush, in_valid, data_IN, out_ready,
    output in_ready, out_valid, data_OUT, count, full, empty
  );

  modport master (
    output flush, in_valid, data_IN, out_ready,
    input  in_ready, out_valid, data_OUT, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stage_fifo
// Brief    : First-word-fall-through FIFO with occupancy count and sync flush.
// Revision : 1.0
// ============================================================================
module stage_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  stage_fifo_if.slave   bus
);
  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

  logic [WIDTH-1:0]      mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic w_full, w_empty, w_push, w_pop;

  assign w_full  = (count_q == c_DEPTH_CNT);
  assign w_empty = (count_q == '0);
  // No write-through when full: in_ready ignores out_ready by design.
  assign w_push  = bus.in_valid & bus.in_ready;
  assign w_pop   = bus.out_valid & bus.out_ready;

  assign bus.in_ready  = ~rst & ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.data_OUT  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (w_pop && !w_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left uncleared by reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) mem_q[wr_ptr_q] <= bus.data_IN;
  end
endmodule
`default_nettype wire

// File: tb/tb_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_fifo
// Brief    : Directed vector table plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_stage_fifo;
  localparam int W  = 8;
  localparam int DL = 2;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();
  stage_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];

  typedef struct {
    logic        r, f, iv;
    logic [7:0]  d;
    logic        ordy;
    logic [14:0] exp;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [7:0] d, logic ordy,
                              logic ir, logic ov, logic [7:0] dout, int cnt);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.exp = {ir, ov, dout, 3'(cnt), (cnt == D), (cnt == 0)};
    return v;
  endfunction

  function automatic logic [14:0] pack_dut();
    return {bus.in_ready, bus.out_valid, bus.data_OUT, bus.count, bus.full, bus.empty};
  endfunction

  function automatic logic [14:0] pack_model();
    int n = mq.size();
    logic [7:0] h = (n > 0) ? mq[0] : 8'h00;
    return {(!rst && n < D), (n > 0), h, 3'(n), (n == D), (n == 0)};
  endfunction

  task automatic compare(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ir=%b ov=%b d=%h cnt=%0d full=%b empty=%b, expected ir=%b ov=%b d=%h cnt=%0d full=%b empty=%b",
               name, act[14], act[13], act[12:5], act[4:2], act[1], act[0],
               exp[14], exp[13], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(logic r, logic f, logic iv, logic [7:0] d, logic ordy);
    @(negedge clk);
    rst = r; bus.flush = f; bus.in_valid = iv; bus.data_IN = d; bus.out_ready = ordy;
    #1;
  endtask

  // Model update from the handshake rules: flush/reset empty it, otherwise pop then push.
  task automatic advance();
    int  n;
    logic push, pop;
    @(posedge clk);
    n = mq.size();
    if (rst || bus.flush) mq.delete();
    else begin
      push = bus.in_valid && (n < D);
      pop  = bus.out_ready && (n > 0);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(bus.data_IN);
    end
  endtask

  task automatic step(string name, logic r, logic f, logic iv, logic [7:0] d, logic ordy);
    drive(r, f, iv, d, ordy);
    compare(name, pack_dut(), pack_model());
    advance();
  endtask

  initial begin
    bit hit;
    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.data_IN = '0; bus.out_ready = 1'b0;

    // reset held two cycles with in_valid asserted
    tv.push_back(mk(1,0,1,8'h99,0, 0,0,8'h00,0));
    tv.push_back(mk(1,0,1,8'h99,0, 0,0,8'h00,0));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,0));
    // fill to full, refused fifth word, drain in order
    tv.push_back(mk(0,0,1,8'h11,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'h22,0, 1,1,8'h11,1));
    tv.push_back(mk(0,0,1,8'h33,0, 1,1,8'h11,2));
    tv.push_back(mk(0,0,1,8'h44,0, 1,1,8'h11,3));
    tv.push_back(mk(0,0,1,8'h55,0, 0,1,8'h11,4));
    tv.push_back(mk(0,0,0,8'h00,1, 0,1,8'h11,4));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h22,3));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h33,2));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'h44,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,0));
    // full with simultaneous pop: push refused
    tv.push_back(mk(0,0,1,8'hA1,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,1,8'hA2,0, 1,1,8'hA1,1));
    tv.push_back(mk(0,0,1,8'hA3,0, 1,1,8'hA1,2));
    tv.push_back(mk(0,0,1,8'hA4,0, 1,1,8'hA1,3));
    tv.push_back(mk(0,0,1,8'hB0,1, 0,1,8'hA1,4));
    tv.push_back(mk(0,0,0,8'h00,0, 1,1,8'hA2,3));
    // flush beats push and pop, then first word after flush
    tv.push_back(mk(0,1,1,8'hC3,1, 1,1,8'hA2,3));
    tv.push_back(mk(0,0,1,8'hA5,0, 1,0,8'h00,0));
    tv.push_back(mk(0,0,0,8'h00,0, 1,1,8'hA5,1));
    tv.push_back(mk(0,0,0,8'h00,1, 1,1,8'hA5,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,8'h00,0));

    @(posedge clk);
    mq.delete();
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].f, tv[i].iv, tv[i].d, tv[i].ordy);
      compare($sformatf("vec%0d", i), pack_dut(), tv[i].exp);
      advance();
    end

    // pointer wrap with steady occupancy of two
    step("wrap_prime0", 0, 0, 1, 8'h80, 0);
    step("wrap_prime1", 0, 0, 1, 8'h81, 0);
    for (int k = 1; k <= 10; k++) step($sformatf("wrap%0d", k), 0, 0, 1, 8'(k), 1);
    for (int k = 0; k < 3; k++) step($sformatf("wrap_drain%0d", k), 0, 0, 0, 8'h00, 1);

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      step($sformatf("rand%0d", c), ($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    // mid-burst reset once occupancy reaches two
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step($sformatf("pre_rst%0d", c), 0, 0, ($urandom_range(0, 1) == 1), 8'($urandom),
           ($urandom_range(0, 3) == 0));
      if (mq.size() == 2) hit = 1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL mid_rst_setup: got no occupancy of 2 within 200 cycles, expected occupancy 2");
    end else begin
      step("mid_rst", 1, 0, 1, 8'h5A, 1);
      drive(0, 0, 0, 8'h00, 0);
      compare("post_rst", pack_dut(), {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1});
      advance();
      step("post_rst_push", 0, 0, 1, 8'h3C, 0);
      step("post_rst_head", 0, 0, 0, 8'h00, 1);
      step("post_rst_empty", 0, 0, 0, 8'h00, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
